mem_port_arbiter: RTL and testbench

Shares one single-port, variable-latency memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store), one transaction at a time. It drives the memory request/acknowledge handshake, returns registered read data with done pulses, and produces the stall signals that freeze the pipeline registers, including EX/MEM, while an access is outstanding. It sits between the pipeline stage logic and the unified memory model, alongside the hazard logic.

---
 rtl/mips_pkg.sv | 18 +
 rtl/sat_counter.sv | 23 ++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline definitions used by the memory port arbiter.
//   arb_state_e - arbiter FSM states
//   DEF_ADDR_W  - default byte address width
//   DEF_DATA_W  - default data width
package mips_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StDmWait,
    StIfWait,
    StDmDone,
    StIfDone
  } arb_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance statistics.
//   clk   - clock
//   rst   - synchronous active-high reset, clears count
//   en    - increment enable, one step per cycle
//   count - current value, holds at all-ones
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between instruction
// fetch (IF) and load/store (MEM). One transaction at a time; MEM has priority.
//   clk, rst                  - clock, synchronous active-high reset
//   if_req/if_addr/if_flush   - fetch request, address, pending-fetch discard
//   if_done/if_rdata          - fetch completion pulse and instruction
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_be            - MEM-stage request
//   dm_done/dm_rdata          - MEM completion pulse and load data
//   stall_if/stall_pipe       - pipeline freeze controls
//   mem_*                     - memory request/ack handshake
//   stall_cnt                 - saturating count of stall cycles
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_done,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                stall_if,
  output logic                stall_pipe,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [CNT_W-1:0]    stall_cnt
);

  arb_state_e state_q;
  logic       drop_q;
  logic       issue_dm;
  logic       issue_if;

  // A requester is ignored in its own done cycle: its req is still high until
  // the stage advances on this edge.
  always_comb begin
    issue_dm = 1'b0;
    issue_if = 1'b0;
    issue_dm = dm_req && ((state_q == StIdle) || (state_q == StIfDone));
    issue_if = if_req && !if_flush &&
               (((state_q == StIdle) && !dm_req) || (state_q == StDmDone));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      drop_q    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if (issue_dm) begin
        state_q   <= StDmWait;
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_be;
      end else if (issue_if) begin
        state_q   <= StIfWait;
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
      end else begin
        case (state_q)
          StDmWait: begin
            if (mem_ack) begin
              state_q <= StDmDone;
              mem_req <= 1'b0;
              dm_done <= 1'b1;
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end
          end
          StIfWait: begin
            // A flushed fetch cannot be cancelled on the bus; wait for the ack
            // and then discard the data silently.
            if (mem_ack) begin
              mem_req <= 1'b0;
              drop_q  <= 1'b0;
              if (drop_q || if_flush) begin
                state_q <= StIdle;
              end else begin
                state_q  <= StIfDone;
                if_done  <= 1'b1;
                if_rdata <= mem_rdata;
              end
            end else if (if_flush) begin
              drop_q <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign stall_pipe = dm_req && !dm_done;
  // IF_WAIT keeps IF stalled even after a flush has dropped if_req.
  assign stall_if   = (if_req && !if_done) || stall_pipe || (state_q == StIfWait);

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (stall_if),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 6;
  localparam int          CMAX = 63;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, if_done;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_done;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic [3:0]    dm_be;
  logic          stall_if, stall_pipe;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_be;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .dm_done   (dm_done),
    .dm_rdata  (dm_rdata),
    .stall_if  (stall_if),
    .stall_pipe(stall_pipe),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall_cnt (stall_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // in  = {rst, if_req, if_flush, dm_req, dm_we, mem_ack}
  // ex  = {mem_req, mem_we, if_done, dm_done, stall_if, stall_pipe}
  typedef struct {
    logic [5:0]  in;
    logic [31:0] ifa, dma, wd, rd;
    logic [3:0]  be;
    logic [5:0]  ex;
    logic [31:0] e_addr, e_ifr, e_dmr, e_wd;
    logic [3:0]  e_be;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic [5:0] in, input logic [31:0] ifa, input logic [31:0] dma,
                     input logic [31:0] wd, input logic [31:0] rd, input logic [3:0] be,
                     input logic [5:0] ex, input logic [31:0] e_addr, input logic [31:0] e_ifr,
                     input logic [31:0] e_dmr, input logic [31:0] e_wd, input logic [3:0] e_be);
    vec_t v;
    v.in = in; v.ifa = ifa; v.dma = dma; v.wd = wd; v.rd = rd; v.be = be;
    v.ex = ex; v.e_addr = e_addr; v.e_ifr = e_ifr; v.e_dmr = e_dmr;
    v.e_wd = e_wd; v.e_be = e_be;
    tbl.push_back(v);
  endtask

  task automatic clear_inputs();
    if_req = 0; if_flush = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Reference model state
  bit          m_busy, m_who_dm, m_drop, m_dd, m_id;
  logic [31:0] m_ifr, m_dmr, m_addr, m_wd;
  logic [3:0]  m_be;
  bit          m_we;
  int          m_cnt;

  initial begin
    bit e_sp, e_si, p_dd, p_id, nd, ni, flush_now;

    do_reset();
    @(negedge clk);
    chk("reset mem_req", 32'(mem_req), 0);
    chk("reset if_done", 32'(if_done), 0);
    chk("reset dm_done", 32'(dm_done), 0);
    chk("reset if_rdata", if_rdata, 0);
    chk("reset dm_rdata", dm_rdata, 0);
    chk("reset stall_cnt", 32'(stall_cnt), 0);
    @(posedge clk); #1;

    // Lone IF fetch at 0x40, ack at cycle 3
    row(6'b010000, 'h40, 0, 0, 0, 0, 6'b000010, 0, 0, 0, 0, 0);
    row(6'b010000, 'h40, 0, 0, 0, 0, 6'b100010, 'h40, 0, 0, 0, 0);
    row(6'b010000, 'h40, 0, 0, 0, 0, 6'b100010, 'h40, 0, 0, 0, 0);
    row(6'b010001, 'h40, 0, 0, 'h11111111, 0, 6'b100010, 'h40, 0, 0, 0, 0);
    row(6'b010000, 'h40, 0, 0, 0, 0, 6'b001000, 0, 'h11111111, 0, 0, 0);
    row(6'b000000, 0, 0, 0, 0, 0, 6'b000000, 0, 'h11111111, 0, 0, 0);
    // Simultaneous load 0x1000 and fetch 0x44, 1-cycle ack each
    row(6'b010100, 'h44, 'h1000, 0, 0, 0, 6'b000011, 0, 'h11111111, 0, 0, 0);
    row(6'b010101, 'h44, 'h1000, 0, 'h22222222, 0, 6'b100011, 'h1000, 'h11111111, 0, 0, 0);
    row(6'b010100, 'h44, 'h1000, 0, 0, 0, 6'b000110, 0, 'h11111111, 'h22222222, 0, 0);
    row(6'b010001, 'h44, 0, 0, 'h33333333, 0, 6'b100010, 'h44, 'h11111111, 'h22222222, 0, 0);
    row(6'b010000, 'h44, 0, 0, 0, 0, 6'b001000, 0, 'h33333333, 'h22222222, 0, 0);
    row(6'b000000, 0, 0, 0, 0, 0, 6'b000000, 0, 'h33333333, 'h22222222, 0, 0);
    // Store 0xDEADBEEF, be 0011, to 0x2000
    row(6'b000110, 0, 'h2000, 'hDEADBEEF, 0, 4'b0011, 6'b000011, 0, 'h33333333, 'h22222222, 0, 0);
    row(6'b000110, 0, 'h2000, 'hDEADBEEF, 0, 4'b0011, 6'b110011, 'h2000, 'h33333333,
        'h22222222, 'hDEADBEEF, 4'b0011);
    row(6'b000111, 0, 'h2000, 'hDEADBEEF, 'h55555555, 4'b0011, 6'b110011, 'h2000, 'h33333333,
        'h22222222, 'hDEADBEEF, 4'b0011);
    row(6'b000110, 0, 'h2000, 'hDEADBEEF, 0, 4'b0011, 6'b000100, 0, 'h33333333, 'h22222222, 0, 0);
    row(6'b000000, 0, 0, 0, 0, 0, 6'b000000, 0, 'h33333333, 'h22222222, 0, 0);
    // Flush mid-fetch: flush at cycle 2, ack at cycle 5
    row(6'b010000, 'h80, 0, 0, 0, 0, 6'b000010, 0, 'h33333333, 'h22222222, 0, 0);
    row(6'b010000, 'h80, 0, 0, 0, 0, 6'b100010, 'h80, 'h33333333, 'h22222222, 0, 0);
    row(6'b011000, 'h80, 0, 0, 0, 0, 6'b100010, 'h80, 'h33333333, 'h22222222, 0, 0);
    row(6'b000000, 0, 0, 0, 0, 0, 6'b100010, 'h80, 'h33333333, 'h22222222, 0, 0);
    row(6'b000000, 0, 0, 0, 0, 0, 6'b100010, 'h80, 'h33333333, 'h22222222, 0, 0);
    row(6'b000001, 0, 0, 0, 'h66666666, 0, 6'b100010, 'h80, 'h33333333, 'h22222222, 0, 0);
    row(6'b000000, 0, 0, 0, 0, 0, 6'b000000, 0, 'h33333333, 'h22222222, 0, 0);
    row(6'b000000, 0, 0, 0, 0, 0, 6'b000000, 0, 'h33333333, 'h22222222, 0, 0);
    // Reset in DM_WAIT, stray ack next cycle, then a normal fetch
    row(6'b000100, 0, 'h3000, 0, 0, 0, 6'b000011, 0, 'h33333333, 'h22222222, 0, 0);
    row(6'b100100, 0, 'h3000, 0, 0, 0, 6'b100011, 'h3000, 'h33333333, 'h22222222, 0, 0);
    row(6'b000001, 0, 0, 0, 'h77777777, 0, 6'b000000, 0, 0, 0, 0, 0);
    row(6'b010000, 'h90, 0, 0, 0, 0, 6'b000010, 0, 0, 0, 0, 0);
    row(6'b010001, 'h90, 0, 0, 'h88888888, 0, 6'b100010, 'h90, 0, 0, 0, 0);
    row(6'b010000, 'h90, 0, 0, 0, 0, 6'b001000, 0, 'h88888888, 0, 0, 0);
    row(6'b000000, 0, 0, 0, 0, 0, 6'b000000, 0, 'h88888888, 0, 0, 0);

    foreach (tbl[i]) begin
      {rst, if_req, if_flush, dm_req, dm_we, mem_ack} = tbl[i].in;
      if_addr = tbl[i].ifa; dm_addr = tbl[i].dma; dm_wdata = tbl[i].wd;
      mem_rdata = tbl[i].rd; dm_be = tbl[i].be;
      @(negedge clk);
      chk($sformatf("row%0d mem_req", i), 32'(mem_req), 32'(tbl[i].ex[5]));
      chk($sformatf("row%0d if_done", i), 32'(if_done), 32'(tbl[i].ex[3]));
      chk($sformatf("row%0d dm_done", i), 32'(dm_done), 32'(tbl[i].ex[2]));
      chk($sformatf("row%0d stall_if", i), 32'(stall_if), 32'(tbl[i].ex[1]));
      chk($sformatf("row%0d stall_pipe", i), 32'(stall_pipe), 32'(tbl[i].ex[0]));
      chk($sformatf("row%0d if_rdata", i), if_rdata, tbl[i].e_ifr);
      chk($sformatf("row%0d dm_rdata", i), dm_rdata, tbl[i].e_dmr);
      if (tbl[i].ex[5]) begin
        chk($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].e_addr);
        chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(tbl[i].ex[4]));
      end
      if (tbl[i].ex[4]) begin
        chk($sformatf("row%0d mem_wdata", i), mem_wdata, tbl[i].e_wd);
        chk($sformatf("row%0d mem_be", i), 32'(mem_be), 32'(tbl[i].e_be));
      end
      @(posedge clk); #1;
    end

    // Counter saturation: a load that never acks stalls every cycle
    do_reset();
    dm_req = 1; dm_addr = 'h4000;
    repeat (CMAX - 1) @(posedge clk);
    @(negedge clk);
    chk("sat near-max", 32'(stall_cnt), CMAX - 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat hold", 32'(stall_cnt), CMAX);
    @(posedge clk); #1;
    mem_ack = 1; mem_rdata = 'hA5A5A5A5;
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    chk("sat dm_done", 32'(dm_done), 1);
    chk("sat dm_rdata", dm_rdata, 'hA5A5A5A5);
    @(posedge clk); #1;
    dm_req = 0;
    @(negedge clk);
    chk("sat after", 32'(stall_cnt), CMAX);
    @(posedge clk); #1;

    // Randomized traffic against the transaction-level model
    do_reset();
    m_busy = 0; m_who_dm = 0; m_drop = 0; m_dd = 0; m_id = 0;
    m_ifr = 0; m_dmr = 0; m_addr = 0; m_wd = 0; m_be = 0; m_we = 0; m_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      e_sp = dm_req && !m_dd;
      e_si = (if_req && !m_id) || e_sp || (m_busy && !m_who_dm);
      chk("rnd mem_req", 32'(mem_req), 32'(m_busy));
      chk("rnd if_done", 32'(if_done), 32'(m_id));
      chk("rnd dm_done", 32'(dm_done), 32'(m_dd));
      chk("rnd stall_if", 32'(stall_if), 32'(e_si));
      chk("rnd stall_pipe", 32'(stall_pipe), 32'(e_sp));
      chk("rnd stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      chk("rnd if_rdata", if_rdata, m_ifr);
      chk("rnd dm_rdata", dm_rdata, m_dmr);
      if (m_busy) begin
        chk("rnd mem_addr", mem_addr, m_addr);
        chk("rnd mem_we", 32'(mem_we), 32'(m_we));
        if (m_we) begin
          chk("rnd mem_wdata", mem_wdata, m_wd);
          chk("rnd mem_be", 32'(mem_be), 32'(m_be));
        end
      end
      @(posedge clk);
      p_dd = m_dd; p_id = m_id;
      if (e_si && m_cnt < CMAX) m_cnt++;
      nd = 0; ni = 0;
      if (m_busy) begin
        if (mem_ack) begin
          m_busy = 0;
          if (m_who_dm) begin
            if (!m_we) m_dmr = mem_rdata;
            nd = 1;
          end else begin
            if (!(m_drop || if_flush)) begin
              m_ifr = mem_rdata;
              ni = 1;
            end
            m_drop = 0;
          end
        end else if (!m_who_dm && if_flush) begin
          m_drop = 1;
        end
      end else if (dm_req && !m_dd) begin
        m_busy = 1; m_who_dm = 1; m_addr = dm_addr; m_we = dm_we; m_wd = dm_wdata; m_be = dm_be;
      end else if (if_req && !if_flush && !m_id) begin
        m_busy = 1; m_who_dm = 0; m_addr = if_addr; m_we = 0;
      end
      m_dd = nd; m_id = ni;
      #1;
      flush_now = if_flush;
      if_flush = ($urandom % 16) == 0;
      if (p_id || flush_now || !if_req) begin
        if_req = $urandom % 2;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (p_dd || !dm_req) begin
        dm_req = ($urandom % 3) == 0;
        dm_we = $urandom % 2;
        dm_addr = $urandom & 32'hFFFF_FFFC;
        dm_wdata = $urandom;
        dm_be = 4'($urandom);
      end
      mem_ack = m_busy && (($urandom % 3) == 0);
      mem_rdata = $urandom;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
